pixel_shader_arbiter: RTL and testbench

- Shares one pixel_shader_cdc datapath (shader input side, clk domain) between NUM_REQ pixel sources.
- Each source has a valid/ready handshake. Grants are round-robin, in bursts of up to BURST_MAX pixels.
- Every issued pixel is tagged with its requester id. The tag travels a fixed-latency shadow pipe so each shader result is routed back to its originator.

---
 rtl/pixel_shader_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_pixel_shader_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_shader_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_shader_arbiter
//  Description : Round-robin, burst-limited arbiter that shares one shader
//                datapath between NUM_REQ pixel sources. Each issued pixel
//                carries its requester id down a fixed-latency shadow pipe,
//                so every shader result is routed back to its originator.
//                Optional per-requester beat counters are built when the
//                macro PIXEL_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_shader_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 16,
    parameter int SHADER_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [24*NUM_REQ-1:0]      req_rgb,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 shd_r,
    output logic [7:0]                 shd_g,
    output logic [7:0]                 shd_b,
    output logic                       shd_valid,
    input  logic [7:0]                 shd_res_r,
    input  logic [7:0]                 shd_res_g,
    input  logic [7:0]                 shd_res_b,
    input  logic                       shd_res_valid,
    output logic [23:0]                resp_rgb,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic                       busy,
`ifdef PIXEL_ARB_STATS_EN
    input  logic [$clog2(NUM_REQ)-1:0] stat_sel,
    output logic [15:0]                stat_beats,
`endif
    output logic                       err_seq
);

    localparam int         c_ID_W      = $clog2(NUM_REQ);
    localparam logic [7:0] c_BURST_MAX = 8'(BURST_MAX);
    localparam logic [0:0] c_S_IDLE    = 1'b0;
    localparam logic [0:0] c_S_BURST   = 1'b1;

    // Arbitration / burst state. r_owner doubles as "last owner": it keeps
    // the id of the most recent grant, which is exactly the round-robin
    // pointer for the next arbitration.
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [c_ID_W-1:0] r_owner;
    logic [7:0]        r_beat_cnt;

    logic              w_grant_found;
    logic [c_ID_W-1:0] w_grant_id;
    logic              w_owner_valid;
    logic              w_owner_last;
    logic [23:0]       w_owner_rgb;
    logic              w_xfer;
    logic [7:0]        w_beat_inc;
    logic              w_burst_done;

    // Shader-side pixel register and tag shadow pipe.
    logic              r_shd_valid;
    logic [23:0]       r_shd_rgb;
    logic [c_ID_W-1:0] r_shd_id;
    logic [SHADER_LAT-1:0] r_tag_v;
    logic [c_ID_W-1:0]     r_tag_id [SHADER_LAT];
    logic                  w_tag_v_out;
    logic [c_ID_W-1:0]     w_tag_id_out;
    logic [NUM_REQ-1:0]    w_tag_onehot;

    // Response path.
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [23:0]        r_resp_rgb;
    logic               r_err_seq;

    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_owner_rgb   = req_rgb[int'(r_owner)*24 +: 24];
    assign w_xfer        = (r_state == c_S_BURST) && w_owner_valid;
    assign w_beat_inc    = r_beat_cnt + 8'd1;
    // A burst closes on a tagged last pixel, on the beat limit, or when the
    // owner drops valid (no transfer happens in that cycle).
    assign w_burst_done  = (w_xfer && (w_owner_last || (w_beat_inc == c_BURST_MAX))) ||
                           ((r_state == c_S_BURST) && !w_owner_valid);

    // Round-robin search starting just after the previous owner, with wrap.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_grant_found && req_valid[(int'(r_owner) + i) % NUM_REQ]) begin
                w_grant_found = 1'b1;
                w_grant_id    = c_ID_W'((int'(r_owner) + i) % NUM_REQ);
            end
        end
    end

    // Next-state logic; IDLE after every burst is where re-arbitration happens.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_grant_found) w_state_nxt = c_S_BURST;
            c_S_BURST: if (w_burst_done)  w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Ready is decoded from registered state only, never from req_valid.
    always_comb begin
        req_ready = '0;
        if (r_state == c_S_BURST) req_ready[r_owner] = 1'b1;
    end

    // State register, grant capture and beat counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_owner    <= c_ID_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_S_IDLE) && w_grant_found) begin
                r_owner    <= w_grant_id;
                r_beat_cnt <= '0;
            end else if (w_xfer) begin
                r_beat_cnt <= w_beat_inc;
            end
        end
    end

    // Present the accepted pixel to the shader one cycle after the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd_valid <= 1'b0;
            r_shd_rgb   <= '0;
            r_shd_id    <= '0;
        end else begin
            r_shd_valid <= w_xfer;
            if (w_xfer) begin
                r_shd_rgb <= w_owner_rgb;
                r_shd_id  <= r_owner;
            end
        end
    end

    // Tag shadow pipe: its last stage lines up with the shader result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int k = 0; k < SHADER_LAT; k++) r_tag_id[k] <= '0;
        end else begin
            r_tag_v[0]  <= r_shd_valid;
            r_tag_id[0] <= r_shd_id;
            for (int k = 1; k < SHADER_LAT; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    assign w_tag_v_out  = r_tag_v[SHADER_LAT-1];
    assign w_tag_id_out = r_tag_id[SHADER_LAT-1];
    assign w_tag_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_tag_id_out;

    // Route matched results to their owner; flag any result/tag disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= '0;
            r_resp_rgb   <= '0;
            r_err_seq    <= 1'b0;
        end else begin
            if (shd_res_valid && w_tag_v_out) begin
                r_resp_valid <= w_tag_onehot;
                r_resp_rgb   <= {shd_res_r, shd_res_g, shd_res_b};
            end else begin
                r_resp_valid <= '0;
                if (shd_res_valid ^ w_tag_v_out) r_err_seq <= 1'b1;
            end
        end
    end

`ifdef PIXEL_ARB_STATS_EN
    logic [15:0] r_stat_cnt [NUM_REQ];
    logic [15:0] r_stat_beats;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stat_cnt
            // Count pixels accepted from this requester, sticking at full scale.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stat_cnt[gi] <= '0;
                end else if (w_xfer && (r_owner == c_ID_W'(gi)) && (r_stat_cnt[gi] != 16'hFFFF)) begin
                    r_stat_cnt[gi] <= r_stat_cnt[gi] + 16'd1;
                end
            end
        end
    endgenerate

    // Registered read port for the selected counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_beats <= '0;
        end else if (int'(stat_sel) < NUM_REQ) begin
            r_stat_beats <= r_stat_cnt[stat_sel];
        end else begin
            r_stat_beats <= '0;
        end
    end

    assign stat_beats = r_stat_beats;
`endif

    assign shd_valid  = r_shd_valid;
    assign shd_r      = r_shd_rgb[23:16];
    assign shd_g      = r_shd_rgb[15:8];
    assign shd_b      = r_shd_rgb[7:0];
    assign resp_valid = r_resp_valid;
    assign resp_rgb   = r_resp_rgb;
    assign err_seq    = r_err_seq;
    assign busy       = (r_state == c_S_BURST) || r_shd_valid || (|r_tag_v);

endmodule
`default_nettype wire

// File: tb/tb_pixel_shader_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_shader_arbiter
//  Description : Directed self-checking bench for pixel_shader_arbiter with a
//                fixed-latency inverting shader model. Stats checks are built
//                when PIXEL_ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_shader_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int BURST_MAX  = 16;
    localparam int SHADER_LAT = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [95:0] req_rgb;
    logic [3:0]  req_ready;
    logic [7:0]  shd_r, shd_g, shd_b;
    logic        shd_valid;
    logic [7:0]  shd_res_r, shd_res_g, shd_res_b;
    logic        shd_res_valid;
    logic [23:0] resp_rgb;
    logic [3:0]  resp_valid;
    logic        busy;
    logic        err_seq;
`ifdef PIXEL_ARB_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_beats;
`endif

    pixel_shader_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BURST_MAX  (BURST_MAX),
        .SHADER_LAT (SHADER_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_rgb       (req_rgb),
        .req_ready     (req_ready),
        .shd_r         (shd_r),
        .shd_g         (shd_g),
        .shd_b         (shd_b),
        .shd_valid     (shd_valid),
        .shd_res_r     (shd_res_r),
        .shd_res_g     (shd_res_g),
        .shd_res_b     (shd_res_b),
        .shd_res_valid (shd_res_valid),
        .resp_rgb      (resp_rgb),
        .resp_valid    (resp_valid),
        .busy          (busy),
`ifdef PIXEL_ARB_STATS_EN
        .stat_sel      (stat_sel),
        .stat_beats    (stat_beats),
`endif
        .err_seq       (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shader model: returns the bitwise inverse of each pixel SHADER_LAT cycles later.
    logic [2:0]  mdl_v;
    logic [23:0] mdl_px [3];
    logic        inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_v     <= '0;
            mdl_px[0] <= '0;
            mdl_px[1] <= '0;
            mdl_px[2] <= '0;
        end else begin
            mdl_v[0]  <= shd_valid;
            mdl_v[1]  <= mdl_v[0];
            mdl_v[2]  <= mdl_v[1];
            mdl_px[0] <= {shd_r, shd_g, shd_b};
            mdl_px[1] <= mdl_px[0];
            mdl_px[2] <= mdl_px[1];
        end
    end

    assign shd_res_valid = mdl_v[2] | inj;
    assign {shd_res_r, shd_res_g, shd_res_b} = ~mdl_px[2];

    int n_cmp;
    int n_bad;
    int cyc;

    // Per-requester source queues.
    logic [23:0] src_px   [4][32];
    logic        src_last [4][32];
    int          src_len  [4];
    int          src_ptr  [4];
    int          src_dly  [4];

    // Observation logs.
    int          x_n;
    int          x_id  [64];
    int          x_cyc [64];
    logic [23:0] x_px  [64];
    int          sv_n;
    int          sv_cyc [64];
    logic [23:0] sv_px  [64];
    int          rs_n;
    int          rs_cyc [64];
    logic [3:0]  rs_oh  [64];
    logic [23:0] rs_rgb [64];

    task automatic clear_logs();
        x_n = 0; sv_n = 0; rs_n = 0;
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0; src_ptr[i] = 0; src_dly[i] = 0;
        end
    endtask

    task automatic drive_sources(input int k);
        for (int i = 0; i < 4; i++) begin
            if (src_ptr[i] < src_len[i] && k >= src_dly[i]) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = src_last[i][src_ptr[i]];
                req_rgb[i*24 +: 24]  = src_px[i][src_ptr[i]];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_rgb[i*24 +: 24]  = '0;
            end
        end
    endtask

    // Runs n cycles, popping sources on handshakes and logging DUT activity.
    task automatic run(input int n);
        logic [3:0] acc;
        drive_sources(0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && x_n < 64) begin
                    x_id[x_n] = i; x_cyc[x_n] = cyc; x_px[x_n] = req_rgb[i*24 +: 24];
                    x_n++;
                end
            end
            if (shd_valid && sv_n < 64) begin
                sv_cyc[sv_n] = cyc; sv_px[sv_n] = {shd_r, shd_g, shd_b};
                sv_n++;
            end
            if (resp_valid != 4'b0 && rs_n < 64) begin
                rs_cyc[rs_n] = cyc; rs_oh[rs_n] = resp_valid; rs_rgb[rs_n] = resp_rgb;
                rs_n++;
            end
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < 4; i++) if (acc[i]) src_ptr[i]++;
            drive_sources(k + 1);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (shd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_shd_valid: got %b expected 0", shd_valid); end
        n_cmp++; if ({shd_r, shd_g, shd_b} !== 24'h0) begin n_bad++; $display("FAIL reset_shd_rgb: got %h expected 000000", {shd_r, shd_g, shd_b}); end
        n_cmp++; if (resp_valid !== 4'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
        n_cmp++; if (resp_rgb !== 24'h0) begin n_bad++; $display("FAIL reset_resp_rgb: got %h expected 000000", resp_rgb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL reset_err_seq: got %b expected 0", err_seq); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL post_reset_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_id [16] = '{0,0,1,1,2,2,3,3,0,0,1,1,2,2,3,3};
        int exp_d;
        int per_req [4];
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 4;
            per_req[i] = 0;
            for (int k = 0; k < 4; k++) begin
                src_px[i][k]   = {4'(i), 4'hA, 8'(k), 8'h3C};
                src_last[i][k] = (k % 2 == 1);
            end
        end
        run(34);
        n_cmp++; if (x_n !== 16) begin n_bad++; $display("FAIL rr_xfer_count: got %0d expected 16", x_n); end
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (x_id[j] !== exp_id[j]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", j, x_id[j], exp_id[j]); end
        end
        for (int j = 1; j < 16; j++) begin
            exp_d = (j % 2 == 1) ? 1 : 2;
            n_cmp++; if (x_cyc[j] - x_cyc[j-1] !== exp_d) begin n_bad++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", j, x_cyc[j] - x_cyc[j-1], exp_d); end
        end
        n_cmp++; if (rs_n !== 16) begin n_bad++; $display("FAIL rr_resp_count: got %0d expected 16", rs_n); end
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (rs_oh[j] !== (4'b0001 << exp_id[j])) begin n_bad++; $display("FAIL rr_resp_owner[%0d]: got %b expected %b", j, rs_oh[j], 4'b0001 << exp_id[j]); end
            n_cmp++; if (rs_rgb[j] !== ~x_px[j]) begin n_bad++; $display("FAIL rr_resp_rgb[%0d]: got %h expected %h", j, rs_rgb[j], ~x_px[j]); end
            for (int i = 0; i < 4; i++) if (rs_oh[j][i]) per_req[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (per_req[i] !== 4) begin n_bad++; $display("FAIL rr_per_req[%0d]: got %0d expected 4", i, per_req[i]); end
        end
    endtask

`ifdef PIXEL_ARB_STATS_EN
    task automatic test_stats();
        stat_sel = 2'd2;
        @(posedge clk);
        #1;
        n_cmp++; if (stat_beats !== 16'd4) begin n_bad++; $display("FAIL stats_req2: got %0d expected 4", stat_beats); end
        stat_sel = 2'd1;
        @(posedge clk);
        #1;
        n_cmp++; if (stat_beats !== 16'd4) begin n_bad++; $display("FAIL stats_req1: got %0d expected 4", stat_beats); end
    endtask
`endif

    task automatic test_single();
        logic [23:0] exp_px  [3];
        logic [23:0] exp_res [3];
        int start;
        exp_px[0]  = 24'hA5FF00; exp_px[1]  = 24'h112233; exp_px[2]  = 24'h445566;
        exp_res[0] = 24'h5A00FF; exp_res[1] = 24'hEEDDCC; exp_res[2] = 24'hBBAA99;
        clear_logs();
        src_len[2] = 3;
        for (int k = 0; k < 3; k++) begin
            src_px[2][k] = exp_px[k]; src_last[2][k] = (k == 2);
        end
        start = cyc;
        run(12);
        n_cmp++; if (x_n !== 3) begin n_bad++; $display("FAIL single_xfer_count: got %0d expected 3", x_n); end
        n_cmp++; if (x_cyc[0] - start !== 1) begin n_bad++; $display("FAIL single_grant_latency: got %0d expected 1", x_cyc[0] - start); end
        n_cmp++; if (sv_n !== 3) begin n_bad++; $display("FAIL single_shd_count: got %0d expected 3", sv_n); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (x_id[j] !== 2) begin n_bad++; $display("FAIL single_owner[%0d]: got %0d expected 2", j, x_id[j]); end
            n_cmp++; if (sv_cyc[j] - start !== j + 2) begin n_bad++; $display("FAIL single_shd_cycle[%0d]: got %0d expected %0d", j, sv_cyc[j] - start, j + 2); end
            n_cmp++; if (sv_px[j] !== exp_px[j]) begin n_bad++; $display("FAIL single_shd_px[%0d]: got %h expected %h", j, sv_px[j], exp_px[j]); end
            n_cmp++; if (rs_oh[j] !== 4'b0100) begin n_bad++; $display("FAIL single_resp_valid[%0d]: got %b expected 0100", j, rs_oh[j]); end
            n_cmp++; if (rs_rgb[j] !== exp_res[j]) begin n_bad++; $display("FAIL single_resp_rgb[%0d]: got %h expected %h", j, rs_rgb[j], exp_res[j]); end
            n_cmp++; if (rs_cyc[j] - x_cyc[j] !== 5) begin n_bad++; $display("FAIL single_latency[%0d]: got %0d expected 5", j, rs_cyc[j] - x_cyc[j]); end
        end
        n_cmp++; if (rs_n !== 3) begin n_bad++; $display("FAIL single_resp_count: got %0d expected 3", rs_n); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL single_err_seq: got %b expected 0", err_seq); end
    endtask

    task automatic test_burst_limit();
        int exp_d;
        clear_logs();
        src_len[1] = 20;
        for (int k = 0; k < 20; k++) begin
            src_px[1][k] = {8'h61, 8'(k), 8'hC3}; src_last[1][k] = 1'b0;
        end
        run(30);
        n_cmp++; if (x_n !== 20) begin n_bad++; $display("FAIL blim_xfer_count: got %0d expected 20", x_n); end
        for (int j = 1; j < 20; j++) begin
            exp_d = (j == 16) ? 2 : 1;
            n_cmp++; if (x_cyc[j] - x_cyc[j-1] !== exp_d) begin n_bad++; $display("FAIL blim_spacing[%0d]: got %0d expected %0d", j, x_cyc[j] - x_cyc[j-1], exp_d); end
        end
        n_cmp++; if (rs_n !== 20) begin n_bad++; $display("FAIL blim_resp_count: got %0d expected 20", rs_n); end
        for (int j = 0; j < 20; j++) begin
            n_cmp++; if (rs_oh[j] !== 4'b0010 || rs_rgb[j] !== ~x_px[j]) begin n_bad++; $display("FAIL blim_resp[%0d]: got %b/%h expected 0010/%h", j, rs_oh[j], rs_rgb[j], ~x_px[j]); end
        end
    endtask

    task automatic test_give_up();
        clear_logs();
        src_len[0] = 2;
        src_px[0][0] = 24'h0A0B0C; src_last[0][0] = 1'b0;
        src_px[0][1] = 24'h0D0E0F; src_last[0][1] = 1'b0;
        src_len[3] = 1; src_dly[3] = 2;
        src_px[3][0] = 24'h303132; src_last[3][0] = 1'b1;
        run(14);
        n_cmp++; if (x_n !== 3) begin n_bad++; $display("FAIL giveup_xfer_count: got %0d expected 3", x_n); end
        n_cmp++; if (x_id[0] !== 0 || x_id[1] !== 0) begin n_bad++; $display("FAIL giveup_first_owner: got %0d,%0d expected 0,0", x_id[0], x_id[1]); end
        n_cmp++; if (x_id[2] !== 3) begin n_bad++; $display("FAIL giveup_next_owner: got %0d expected 3", x_id[2]); end
        n_cmp++; if (x_cyc[2] - x_cyc[1] !== 3) begin n_bad++; $display("FAIL giveup_gap: got %0d expected 3", x_cyc[2] - x_cyc[1]); end
        n_cmp++; if (rs_n !== 3 || rs_oh[2] !== 4'b1000 || rs_rgb[2] !== 24'hCFCECD) begin n_bad++; $display("FAIL giveup_resp: got %0d/%b/%h expected 3/1000/cfcecd", rs_n, rs_oh[2], rs_rgb[2]); end
    endtask

    task automatic test_err_seq();
        n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b expected 0", err_seq); end
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        n_cmp++; if (err_seq !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected 1", err_seq); end
        clear_logs();
        run(6);
        n_cmp++; if (rs_n !== 0) begin n_bad++; $display("FAIL err_no_resp: got %0d responses expected 0", rs_n); end
        n_cmp++; if (err_seq !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", err_seq); end
    endtask

    task automatic test_reset_mid_flight();
        clear_logs();
        src_len[2] = 6;
        for (int k = 0; k < 6; k++) begin
            src_px[2][k] = {8'h22, 8'(k), 8'h77}; src_last[2][k] = 1'b0;
        end
        run(3);
        n_cmp++; if (x_n !== 2 || shd_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got xfers=%0d shd_valid=%b busy=%b expected 2/1/1", x_n, shd_valid, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (shd_valid !== 1'b0 || {shd_r, shd_g, shd_b} !== 24'h0) begin n_bad++; $display("FAIL rstmid_shd: got %b/%h expected 0/000000", shd_valid, {shd_r, shd_g, shd_b}); end
        n_cmp++; if (resp_valid !== 4'b0 || resp_rgb !== 24'h0) begin n_bad++; $display("FAIL rstmid_resp: got %b/%h expected 0000/000000", resp_valid, resp_rgb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_cmp++; if (err_seq !== 1'b0) begin n_bad++; $display("FAIL rstmid_err_seq: got %b expected 0", err_seq); end
        clear_logs();
        drive_sources(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(10);
        n_cmp++; if (rs_n !== 0) begin n_bad++; $display("FAIL rstmid_stale_resp: got %0d responses expected 0", rs_n); end
        n_cmp++; if (sv_n !== 0) begin n_bad++; $display("FAIL rstmid_stale_shd: got %0d pixels expected 0", sv_n); end
        n_cmp++; if (err_seq !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_after: got err=%b busy=%b expected 0/0", err_seq, busy); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        inj       = 1'b0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_rgb   = '0;
`ifdef PIXEL_ARB_STATS_EN
        stat_sel  = '0;
`endif
        clear_logs();
        test_reset();
        test_round_robin();
`ifdef PIXEL_ARB_STATS_EN
        test_stats();
`endif
        test_single();
        test_burst_limit();
        test_give_up();
        test_err_seq();
        test_reset_mid_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
